// File: rtl/point_to_dma.sv
// point_to_dma: DMA-domain read side of one lane of the NTT->DMA point FIFO.
// Synchronizes the writer's gray coarse pointer and drains each completed coarse
// block as NPPCH-wide beats in address order. A credit-limited output buffer
// absorbs RAM read latency and downstream back-pressure.
module point_to_dma #(
    parameter int unsigned POINT_W     = 64,
    parameter int unsigned NPPCH       = 4,
    parameter int unsigned FINE_W      = 4,
    parameter int unsigned CD_W        = 2,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [CD_W:0]                 wcoarse_i,
    output logic [CD_W:0]                 rcoarse_o,
    output logic                          re_o,
    output logic [CD_W+FINE_W-1:0]        raddr_o,
    input  logic [NPPCH*POINT_W-1:0]      rdata_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NPPCH*POINT_W-1:0]      data_o,
    output logic                          overflow_o
);

    localparam int unsigned PTR_W  = CD_W + 1;
    localparam int unsigned ADDR_W = CD_W + FINE_W;
    localparam int unsigned DATA_W = NPPCH * POINT_W;
    localparam int unsigned DEPTH  = RD_LAT + 2;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] HALF_VOL = PTR_W'(2 ** CD_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic [PTR_W-1:0] gray_to_bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_W-1:0] bin_to_gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    logic [PTR_W-1:0]  sync_q [SYNC_STAGES];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [FINE_W-1:0] fine_q, fine_d;
    logic [1:0]        state_q, state_d;
    logic              re_d;
    logic [ADDR_W-1:0] raddr_d;

    logic [PTR_W-1:0]  volume_c, volume_next_c;
    logic              avail_c, avail_next_c;

    logic [RD_LAT-1:0] vld_q;
    logic              push_c, pop_c, can_issue_c;
    logic [CNT_W-1:0]  inflight_all_c, inflight_tail_c;

    logic [DATA_W-1:0] buf_mem [DEPTH];
    logic [IDX_W-1:0]  wr_idx_q, rd_idx_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Write-pointer synchronizer, gray decode and sticky overflow detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            wptr_q     <= '0;
            overflow_o <= 1'b0;
        end else begin
            sync_q[0] <= wcoarse_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            wptr_q     <= gray_to_bin(sync_q[SYNC_STAGES-1]);
            overflow_o <= overflow_o | (volume_c > HALF_VOL);
        end
    end

    // Block availability against the current and the about-to-advance read pointer.
    always_comb begin
        volume_c      = wptr_q - rptr_q;
        volume_next_c = wptr_q - (rptr_q + PTR_W'(1));
        avail_c       = (volume_c != '0);
        avail_next_c  = (volume_next_c != '0);
    end

    // Reads in flight: all of them for credit, and those not landing this cycle for drain.
    always_comb begin
        inflight_all_c  = CNT_W'(re_o);
        inflight_tail_c = CNT_W'(re_o);
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight_all_c = inflight_all_c + CNT_W'(vld_q[i]);
            if (i < int'(RD_LAT) - 1) begin
                inflight_tail_c = inflight_tail_c + CNT_W'(vld_q[i]);
            end
        end
    end

    // Credit: a new read may issue only if every outstanding beat still has a slot.
    always_comb begin
        push_c      = vld_q[RD_LAT-1];
        pop_c       = valid_o && ready_i;
        cnt_d       = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        can_issue_c = (SUM_W'(cnt_q) + SUM_W'(inflight_all_c)) <
                      (SUM_W'(DEPTH) + SUM_W'(pop_c));
    end

    // Read FSM next-state and read-port decode.
    always_comb begin
        state_d = state_q;
        rptr_d  = rptr_q;
        fine_d  = fine_q;
        re_d    = 1'b0;
        raddr_d = raddr_o;
        unique case (state_q)
            ST_IDLE: begin
                if (avail_c) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
            end
            ST_DRAIN: begin
                if (inflight_tail_c == '0) begin
                    rptr_d  = rptr_q + PTR_W'(1);
                    fine_d  = '0;
                    state_d = avail_next_c ? ST_READ : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Issue from READ, or straight out of IDLE so the first read is not delayed.
        if (((state_q == ST_READ) || ((state_q == ST_IDLE) && avail_c)) && can_issue_c) begin
            re_d    = 1'b1;
            raddr_d = {rptr_q[CD_W-1:0], fine_q};
            fine_d  = fine_q + FINE_W'(1);
            if (&fine_q) begin
                state_d = ST_DRAIN;
            end
        end
    end

    // FSM state, read port and published read pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rptr_q    <= '0;
            fine_q    <= '0;
            re_o      <= 1'b0;
            raddr_o   <= '0;
            rcoarse_o <= '0;
        end else begin
            state_q   <= state_d;
            rptr_q    <= rptr_d;
            fine_q    <= fine_d;
            re_o      <= re_d;
            raddr_o   <= raddr_d;
            rcoarse_o <= bin_to_gray(rptr_q);
        end
    end

    // RAM data-valid pipe and output buffer bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            valid_o  <= 1'b0;
        end else begin
            vld_q[0] <= re_o;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (push_c) begin
                wr_idx_q <= next_idx(wr_idx_q);
            end
            if (pop_c) begin
                rd_idx_q <= next_idx(rd_idx_q);
            end
            cnt_q   <= cnt_d;
            valid_o <= (cnt_d != '0);
        end
    end

    // Output buffer storage; contents are don't-care while their slot is empty.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            buf_mem[wr_idx_q] <= rdata_i;
        end
    end

    assign data_o = buf_mem[rd_idx_q];

endmodule

// File: tb/tb_point_to_dma.sv
// Bench for point_to_dma: a RAM model with fixed read latency, a writer that fills
// coarse blocks with random data, and an in-order scoreboard of expected beats.
module tb_point_to_dma;

    localparam int unsigned POINT_W = 64;
    localparam int unsigned NPPCH   = 4;
    localparam int unsigned FINE_W  = 4;
    localparam int unsigned CD_W    = 2;
    localparam int unsigned RD_LAT  = 2;
    localparam int unsigned DATA_W  = NPPCH * POINT_W;
    localparam int unsigned ADDR_W  = CD_W + FINE_W;
    localparam int unsigned NBEAT   = 2 ** FINE_W;
    localparam int unsigned NSLOT   = 2 ** CD_W;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [CD_W:0]      wcoarse_i = '0;
    logic [CD_W:0]      rcoarse_o;
    logic               re_o;
    logic [ADDR_W-1:0]  raddr_o;
    logic [DATA_W-1:0]  rdata_i;
    logic               valid_o;
    logic               ready_i = 1'b0;
    logic [DATA_W-1:0]  data_o;
    logic               overflow_o;

    point_to_dma #(
        .POINT_W(POINT_W), .NPPCH(NPPCH), .FINE_W(FINE_W),
        .CD_W(CD_W), .RD_LAT(RD_LAT), .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wcoarse_i(wcoarse_i), .rcoarse_o(rcoarse_o),
        .re_o(re_o), .raddr_o(raddr_o), .rdata_i(rdata_i), .valid_o(valid_o),
        .ready_i(ready_i), .data_o(data_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [ADDR_W-1:0] addr_pipe [RD_LAT+1];

    // RAM model: data for the address seen in cycle t is presented in cycle t+RD_LAT.
    always @(negedge clk_i) begin
        for (int i = RD_LAT; i > 0; i--) addr_pipe[i] = addr_pipe[i-1];
        addr_pipe[0] = raddr_o;
        rdata_i = ram[addr_pipe[RD_LAT]];
    end

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q [$];
    int wblk = 0;
    int rdy_mode = 0;
    logic stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    function automatic logic [CD_W:0] gray(input int b);
        logic [CD_W:0] x;
        x = (CD_W+1)'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Writer: fill the next coarse block with random points, then publish its pointer.
    task automatic publish();
        int slot;
        logic [DATA_W-1:0] d;
        slot = wblk % NSLOT;
        for (int f = 0; f < int'(NBEAT); f++) begin
            for (int k = 0; k < int'(DATA_W / 32); k++) d[k*32 +: 32] = $urandom();
            ram[slot * NBEAT + f] = d;
            exp_q.push_back(d);
        end
        wblk++;
        wcoarse_i = gray(wblk);
    endtask

    // One cycle: stall-hold check, ready choice, then score any beat taken at the next edge.
    task automatic cyc();
        @(negedge clk_i);
        if (stall_prev) begin
            check("stall_valid", DATA_W'(valid_o), DATA_W'(1'b1));
            check("stall_data", data_o, stall_data);
        end
        case (rdy_mode)
            0: ready_i = 1'b1;
            1: ready_i = ($urandom_range(0, 9) < 3);
            default: ready_i = 1'b0;
        endcase
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) check("unexpected_beat", DATA_W'(valid_o), DATA_W'(1'b0));
            else check("beat_data", data_o, exp_q.pop_front());
        end
        stall_prev = valid_o && !ready_i;
        stall_data = data_o;
    endtask

    // Run until every published beat is out and the read pointer has caught up.
    task automatic drain(input string tag);
        for (int n = 0; n < 3000; n++) begin
            if (exp_q.size() == 0 && rcoarse_o === gray(wblk) && !valid_o) break;
            cyc();
        end
        check({tag, "_beats_left"}, DATA_W'(exp_q.size()), '0);
        check({tag, "_rcoarse"}, DATA_W'(rcoarse_o), DATA_W'(gray(wblk)));
        for (int n = 0; n < 6; n++) cyc();
        check({tag, "_re_idle"}, DATA_W'(re_o), '0);
        check({tag, "_valid_idle"}, DATA_W'(valid_o), '0);
        check({tag, "_overflow"}, DATA_W'(overflow_o), '0);
    endtask

    initial begin
        bit found;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_valid", DATA_W'(valid_o), '0);
        check("rst_re", DATA_W'(re_o), '0);
        check("rst_raddr", DATA_W'(raddr_o), '0);
        check("rst_rcoarse", DATA_W'(rcoarse_o), '0);
        check("rst_overflow", DATA_W'(overflow_o), '0);
        rst_i = 1'b0;

        // Empty FIFO: nothing may be read.
        for (int n = 0; n < 20; n++) begin
            cyc();
            check("empty_re", DATA_W'(re_o), '0);
            check("empty_valid", DATA_W'(valid_o), '0);
        end
        check("empty_rcoarse", DATA_W'(rcoarse_o), '0);

        // Single block with ready held high.
        publish();
        drain("blk1");

        // Four more blocks at once, wrapping the RAM block index.
        for (int b = 0; b < 4; b++) publish();
        drain("blk5");

        // Three blocks under random back-pressure.
        rdy_mode = 1;
        for (int b = 0; b < 3; b++) publish();
        drain("random");

        // Asynchronous reset in the middle of the second of two blocks.
        rdy_mode = 0;
        publish();
        publish();
        found = 0;
        for (int n = 0; n < 500 && !found; n++) begin
            cyc();
            if (re_o && raddr_o == ADDR_W'(((wblk - 1) % NSLOT) * NBEAT + 7)) found = 1;
        end
        check("reach_fine7", DATA_W'(found), DATA_W'(1'b1));
        check("pre_rst_rcoarse", DATA_W'(rcoarse_o), DATA_W'(gray(wblk - 1)));
        #1 rst_i = 1'b1;
        #1;
        check("async_valid", DATA_W'(valid_o), '0);
        check("async_rcoarse", DATA_W'(rcoarse_o), '0);
        check("async_re", DATA_W'(re_o), '0);
        wblk = 0;
        exp_q.delete();
        wcoarse_i = '0;
        stall_prev = 1'b0;
        repeat (3) cyc();
        @(negedge clk_i);
        rst_i = 1'b0;
        publish();
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            cyc();
            if (re_o) found = 1;
        end
        check("restart_seen", DATA_W'(found), DATA_W'(1'b1));
        check("restart_addr", DATA_W'(raddr_o), '0);
        drain("restart");

        // Overflow: writer pointer five blocks ahead, then back to a legal volume.
        rdy_mode = 2;
        wcoarse_i = gray(wblk + 5);
        repeat (10) cyc();
        check("overflow_set", DATA_W'(overflow_o), DATA_W'(1'b1));
        wcoarse_i = gray(wblk + 1);
        repeat (10) cyc();
        check("overflow_sticky", DATA_W'(overflow_o), DATA_W'(1'b1));
        #1 rst_i = 1'b1;
        #1;
        check("overflow_cleared", DATA_W'(overflow_o), '0);
        check("final_valid", DATA_W'(valid_o), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/point_to_dma.md
Name: point_to_dma

Overview:
- Read-side drain for one lane of the NTT→DMA point FIFO. The matching writer streams points into a dual-clock RAM and publishes a gray-coded coarse write pointer.
- This block runs in the DMA clock domain. It synchronizes the write pointer and reads each completed coarse block out as NPPCH-wide beats onto a valid/ready stream.
- It publishes a gray-coded coarse read pointer back to the writer for flow control.
- One instance is placed per lane.

Parameters:
- POINT_W, 64: bits per point.
- NPPCH, 4: points per channel beat (read in parallel, one RAM bank each).
- FINE_W, 4: fine address bits; one coarse block = 2**FINE_W beats.
- CD_W, 2: log2 of FIFO_COARSE_DEPTH. Coarse pointer width = CD_W+1.
- RD_LAT, 2: RAM read latency in cycles, 1..4.
- SYNC_STAGES, 2: synchronizer depth for the write pointer, at least 2.

Ports:
- clk_i, in, 1: DMA-domain clock; the only clock.
- rst_i, in, 1: asynchronous active-high reset.
- wcoarse_i, in, CD_W+1: gray write pointer from the writer domain.
- rcoarse_o, out, CD_W+1: gray read pointer, registered.
- re_o, out, 1: RAM read enable, common to all NPPCH banks.
- raddr_o, out, CD_W+FINE_W: RAM address = {rptr[CD_W-1:0], fine}.
- rdata_i, in, NPPCH*POINT_W: RAM read data, valid RD_LAT cycles after re_o.
- valid_o, out, 1: output beat valid.
- ready_i, in, 1: downstream ready.
- data_o, out, NPPCH*POINT_W: output beat.
- overflow_o, out, 1: sticky error flag.

Behaviour:
- Pointer sync:
  - wcoarse_i passes through SYNC_STAGES flops, then gray→bin, then one register → wptr.
  - Volume = (wptr − rptr) mod 2**(CD_W+1).
  - Block available when volume ≠ 0.
  - overflow_o sets when volume > 2**CD_W and stays set until reset.
- Read FSM states:
  - IDLE: go to READ when a block is available.
  - READ: issue re_o=1 with raddr_o={rptr[CD_W-1:0], fine}, fine++, whenever credit > 0. After issuing fine = 2**FINE_W−1, go to DRAIN.
  - DRAIN: wait until every read of the block has been delivered to the output buffer (in-flight count = 0). Then rptr++, which wraps mod 2**(CD_W+1); fine=0. Go to READ if another block is available, else IDLE.
- Read pointer publication:
  - rcoarse_o = bin_to_gray(rptr), registered, so it updates 1 cycle after the increment.
  - rptr advances only when all data of the block has left the RAM. The writer may then overwrite those entries.
- Credit / output buffer:
  - Output buffer is a FIFO of depth RD_LAT+2.
  - credit = depth − occupancy − in-flight. A read is issued only if credit > 0, so the buffer never overflows.
  - Read data is pushed into the buffer on the RAM data-valid pipe, which is re_o delayed by RD_LAT.
  - valid_o = buffer not empty; data_o = buffer head. A beat transfers when valid_o && ready_i. Push and pop in the same cycle are both honoured.
- Latency (ready_i held high, block available at the idle→read decision):
  - first re_o at cycle 0;
  - valid_o at cycle RD_LAT+1;
  - sustained throughput 1 beat/cycle, including across back-to-back blocks except for the DRAIN bubble (≤ RD_LAT+1 cycles).
- Ordering: beats leave in strict address order: block by block, fine 0..2**FINE_W−1.
- Reset (asynchronous, any state, including mid-block):
  - outputs: valid_o=0, re_o=0, raddr_o=0, rcoarse_o=0, overflow_o=0;
  - FSM → IDLE; rptr=0, fine=0;
  - sync flops cleared; buffer and in-flight pipe emptied.
  - Partially read blocks are discarded; the writer domain must be reset together with this block.
- valid_o/data_o stay stable while valid_o && !ready_i.

Test Plan:
- Reset, then wcoarse_i=0 held → re_o never asserts, valid_o=0, rcoarse_o=0.
- wcoarse_i gray(1) with ready_i=1 → 16 beats in fine order from RAM addresses 0..15; rcoarse_o becomes gray(1) after the last read returns; FSM then idle.
- wcoarse_i steps to gray(5) (5 blocks, crossing the wrap of the 2-bit RAM block index) → 80 beats; raddr block index goes 0,1,2,3,0; rcoarse_o ends at gray(5).
- ready_i random 30% duty across 3 blocks → no beat lost or duplicated; data_o stable while stalled; buffer never exceeds RD_LAT+2.
- wptr set to rptr+5 (volume 5 > 4) → overflow_o=1 and it stays 1 after volume returns to normal.
- Reset asserted at fine=7 of a block with beats in flight → valid_o=0 and rcoarse_o=0 immediately (asynchronous); after release, reading restarts from address 0.
